// File: rtl/conv_layer_sched.sv
// Top-level sequencer for the CONV accelerator: host handshake, engine start/done sequencing, bank selects, watchdog.
// Optional performance counters are enabled by defining CONV_SCHED_PERF_EN.
module conv_layer_sched #(
    parameter int unsigned TIMEOUT_CYC = 200000,
    parameter int unsigned TO_W        = 18
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ready,
    output logic       busy,
    output logic       l0_start,
    input  logic       l0_done,
    output logic       l1_start,
    input  logic       l1_done,
    output logic       l2_start,
    input  logic       l2_done,
    output logic       ksel,
    output logic [2:0] src_sel,
    output logic [2:0] dst_sel,
    output logic       timeout_err
`ifdef CONV_SCHED_PERF_EN
    ,
    output logic [31:0] perf_cycles,
    output logic [2:0]  perf_phase
`endif
);

    typedef enum logic [3:0] {
        IDLE, S_L0K0, W_L0K0, S_L0K1, W_L0K1,
        S_L1K0, W_L1K0, S_L1K1, W_L1K1, S_L2, W_L2
    } state_t;

    localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT_CYC == 0 ? 0 : TIMEOUT_CYC - 1);

    state_t          state, nxt;
    logic            armed;
    logic [TO_W-1:0] wd_cnt;
    logic [2:0]      phase;
    logic            is_wait, phase_done, wd_hit, accept;
    logic [2:0]      nxt_src, nxt_dst;

    always_comb begin
        phase   = 3'd0;
        is_wait = 1'b0;
        case (state)
            S_L0K1, W_L0K1: phase = 3'd1;
            S_L1K0, W_L1K0: phase = 3'd2;
            S_L1K1, W_L1K1: phase = 3'd3;
            S_L2,   W_L2:   phase = 3'd4;
            default:        phase = 3'd0;
        endcase
        is_wait = (state inside {W_L0K0, W_L0K1, W_L1K0, W_L1K1, W_L2});
        case (phase)
            3'd0, 3'd1: phase_done = l0_done;
            3'd2, 3'd3: phase_done = l1_done;
            default:    phase_done = l2_done;
        endcase
        // A done landing on the final allowed cycle takes priority over the abort
        wd_hit = (TIMEOUT_CYC != 0) && is_wait && !phase_done && (wd_cnt == WD_LAST);
        accept = (state == IDLE) && ready && armed;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (accept) nxt = S_L0K0;
            S_L0K0:  nxt = W_L0K0;
            W_L0K0:  if (l0_done) nxt = S_L0K1;
            S_L0K1:  nxt = W_L0K1;
            W_L0K1:  if (l0_done) nxt = S_L1K0;
            S_L1K0:  nxt = W_L1K0;
            W_L1K0:  if (l1_done) nxt = S_L1K1;
            S_L1K1:  nxt = W_L1K1;
            W_L1K1:  if (l1_done) nxt = S_L2;
            S_L2:    nxt = W_L2;
            W_L2:    if (l2_done) nxt = IDLE;
            default: nxt = IDLE;
        endcase
        if (wd_hit) nxt = IDLE;
    end

    always_comb begin
        nxt_src = 3'b000;
        nxt_dst = 3'b000;
        case (nxt)
            S_L0K0, W_L0K0: begin nxt_src = 3'b000; nxt_dst = 3'b001; end
            S_L0K1, W_L0K1: begin nxt_src = 3'b000; nxt_dst = 3'b010; end
            S_L1K0, W_L1K0: begin nxt_src = 3'b001; nxt_dst = 3'b011; end
            S_L1K1, W_L1K1: begin nxt_src = 3'b010; nxt_dst = 3'b100; end
            S_L2,   W_L2:   begin nxt_src = 3'b011; nxt_dst = 3'b101; end
            default:        begin nxt_src = 3'b000; nxt_dst = 3'b000; end
        endcase
    end

    // Outputs are registered from the next-state decode so they track the state register exactly
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            armed       <= 1'b1;
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
            busy        <= 1'b0;
            l0_start    <= 1'b0;
            l1_start    <= 1'b0;
            l2_start    <= 1'b0;
            ksel        <= 1'b0;
            src_sel     <= 3'b000;
            dst_sel     <= 3'b000;
        end else begin
            state <= nxt;
            if (state == IDLE) begin
                if (accept)      armed <= 1'b0;
                else if (!ready) armed <= 1'b1;
            end
            if (is_wait) begin
                if (wd_cnt != '1) wd_cnt <= wd_cnt + 1'b1;
            end else begin
                wd_cnt <= '0;
            end
            if (wd_hit)      timeout_err <= 1'b1;
            else if (accept) timeout_err <= 1'b0;
            busy     <= (nxt != IDLE);
            l0_start <= (nxt inside {S_L0K0, S_L0K1});
            l1_start <= (nxt inside {S_L1K0, S_L1K1});
            l2_start <= (nxt == S_L2);
            ksel     <= (nxt inside {S_L0K1, W_L0K1, S_L1K1, W_L1K1});
            src_sel  <= nxt_src;
            dst_sel  <= nxt_dst;
        end
    end

`ifdef CONV_SCHED_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_cycles <= '0;
            perf_phase  <= '0;
        end else begin
            if (accept)                         perf_cycles <= '0;
            else if (busy && perf_cycles != '1) perf_cycles <= perf_cycles + 1'b1;
            if (wd_hit) perf_phase <= phase;
        end
    end
`endif

endmodule

// File: tb/tb_conv_layer_sched.sv
// Directed self-checking bench for conv_layer_sched (watchdog set to 100 cycles).
// Performance-port checks are included when CONV_SCHED_PERF_EN is defined.
module tb_conv_layer_sched;

    logic       clk = 1'b0;
    logic       reset, ready;
    logic       l0_done, l1_done, l2_done;
    logic       busy, l0_start, l1_start, l2_start, ksel, timeout_err;
    logic [2:0] src_sel, dst_sel;
`ifdef CONV_SCHED_PERF_EN
    logic [31:0] perf_cycles;
    logic [2:0]  perf_phase;
`endif

    int errors = 0;
    int checks = 0;

    conv_layer_sched #(.TIMEOUT_CYC(100), .TO_W(7)) dut (
        .clk         (clk),
        .reset       (reset),
        .ready       (ready),
        .busy        (busy),
        .l0_start    (l0_start),
        .l0_done     (l0_done),
        .l1_start    (l1_start),
        .l1_done     (l1_done),
        .l2_start    (l2_start),
        .l2_done     (l2_done),
        .ksel        (ksel),
        .src_sel     (src_sel),
        .dst_sel     (dst_sel),
        .timeout_err (timeout_err)
`ifdef CONV_SCHED_PERF_EN
        ,
        .perf_cycles (perf_cycles),
        .perf_phase  (perf_phase)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL tb_time_limit: simulation did not complete");
        $fatal(1);
    end

    task tick;
        @(posedge clk);
        #1;
    endtask

    task clear_dones;
        l0_done = 1'b0;
        l1_done = 1'b0;
        l2_done = 1'b0;
    endtask

    task automatic give_done(input int eng);
        case (eng)
            0: l0_done = 1'b1;
            1: l1_done = 1'b1;
            default: l2_done = 1'b1;
        endcase
        tick;
        clear_dones;
    endtask

    // Reset pulse placed mid-cycle, leaves the bench at posedge+1
    task do_reset;
        ready = 1'b0;
        clear_dones;
        reset = 1'b0;
        #4;
        reset = 1'b1;
        tick;
    endtask

    task test_reset;
        ready = 1'b0;
        clear_dones;
        reset = 1'b0;
        #12;
        checks++;
        if ({busy, l0_start, l1_start, l2_start, ksel, src_sel, dst_sel, timeout_err} !== 12'h000) begin
            errors++;
            $display("FAIL reset_values: got busy=%b st=%b%b%b ksel=%b src=%b dst=%b to=%b want all 0",
                     busy, l0_start, l1_start, l2_start, ksel, src_sel, dst_sel, timeout_err);
        end
        #4;
        reset = 1'b1;
        tick;
        tick;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_ready: busy got %b want 0", busy);
        end
    endtask

    task automatic test_nominal;
        int exp_eng [5] = '{0, 0, 1, 1, 2};
        int exp_k   [5] = '{0, 1, 0, 1, 0};
        int exp_src [5] = '{0, 0, 1, 2, 3};
        int exp_dst [5] = '{1, 2, 3, 4, 5};
        int busy_cyc = 0;
        int n_start = 0;
        int cd = 0;
        int eng = 0;
        int code;
        ready = 1'b1;
        tick;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL nominal_busy_rise: got %b want 1", busy);
        end
        for (int i = 0; i < 80; i++) begin
            if (busy !== 1'b1) break;
            busy_cyc++;
            if (l0_start || l1_start || l2_start) begin
                code = l0_start ? 0 : (l1_start ? 1 : 2);
                if (n_start < 5) begin
                    checks++;
                    if (code !== exp_eng[n_start] || int'(ksel) !== exp_k[n_start] ||
                        int'(src_sel) !== exp_src[n_start] || int'(dst_sel) !== exp_dst[n_start]) begin
                        errors++;
                        $display("FAIL nominal_phase%0d: got eng=%0d ksel=%b src=%b dst=%b want eng=%0d ksel=%0d src=%0d dst=%0d",
                                 n_start, code, ksel, src_sel, dst_sel,
                                 exp_eng[n_start], exp_k[n_start], exp_src[n_start], exp_dst[n_start]);
                    end
                end
                n_start++;
                eng = code;
                cd = 5;
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    case (eng)
                        0: l0_done = 1'b1;
                        1: l1_done = 1'b1;
                        default: l2_done = 1'b1;
                    endcase
                end
            end
            tick;
            clear_dones;
        end
        checks++;
        if (busy_cyc != 30) begin
            errors++;
            $display("FAIL nominal_busy_len: got %0d cycles want 30", busy_cyc);
        end
        checks++;
        if (n_start != 5) begin
            errors++;
            $display("FAIL nominal_start_count: got %0d want 5", n_start);
        end
        checks++;
        if (busy !== 1'b0 || src_sel !== 3'b000 || dst_sel !== 3'b000) begin
            errors++;
            $display("FAIL nominal_end_idle: got busy=%b src=%b dst=%b want 0 000 000", busy, src_sel, dst_sel);
        end
`ifdef CONV_SCHED_PERF_EN
        checks++;
        if (perf_cycles !== 32'd30) begin
            errors++;
            $display("FAIL perf_cycles: got %0d want 30", perf_cycles);
        end
`endif
    endtask

    task automatic test_ready_held;
        logic bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (busy !== 1'b0 || l0_start !== 1'b0 || l1_start !== 1'b0 || l2_start !== 1'b0) bad = 1'b1;
            tick;
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++;
            $display("FAIL ready_held_no_restart: got restart=%b want 0", bad);
        end
        ready = 1'b0;
        tick;
        ready = 1'b1;
        tick;
        checks++;
        if (busy !== 1'b1 || l0_start !== 1'b1 || dst_sel !== 3'b001) begin
            errors++;
            $display("FAIL ready_rearm_restart: got busy=%b l0_start=%b dst=%b want 1 1 001", busy, l0_start, dst_sel);
        end
        do_reset;
    endtask

    task test_stray_done;
        ready = 1'b1;
        tick;
        ready = 1'b0;
        tick;
        l1_done = 1'b1;
        tick;
        clear_dones;
        checks++;
        if (busy !== 1'b1 || l0_start !== 1'b0 || l1_start !== 1'b0 || dst_sel !== 3'b001) begin
            errors++;
            $display("FAIL stray_l1_done: got busy=%b l0s=%b l1s=%b dst=%b want 1 0 0 001", busy, l0_start, l1_start, dst_sel);
        end
        tick;
        l0_done = 1'b1;
        tick;
        checks++;
        if (l0_start !== 1'b1 || dst_sel !== 3'b010 || ksel !== 1'b1) begin
            errors++;
            $display("FAIL stray_enter_l0k1: got l0s=%b dst=%b ksel=%b want 1 010 1", l0_start, dst_sel, ksel);
        end
        tick;
        clear_dones;
        checks++;
        if (l0_start !== 1'b0 || l1_start !== 1'b0 || dst_sel !== 3'b010 || busy !== 1'b1) begin
            errors++;
            $display("FAIL stray_done_in_start: got l0s=%b l1s=%b dst=%b busy=%b want 0 0 010 1", l0_start, l1_start, dst_sel, busy);
        end
        tick;
        l0_done = 1'b1;
        tick;
        clear_dones;
        checks++;
        if (l1_start !== 1'b1 || src_sel !== 3'b001 || dst_sel !== 3'b011 || ksel !== 1'b0) begin
            errors++;
            $display("FAIL stray_advance_l1k0: got l1s=%b src=%b dst=%b ksel=%b want 1 001 011 0", l1_start, src_sel, dst_sel, ksel);
        end
        do_reset;
    endtask

    task test_watchdog;
        ready = 1'b1;
        tick;
        ready = 1'b0;
        tick;
        give_done(0);
        tick;
        give_done(0);
        tick;
        repeat (99) tick;
        checks++;
        if (busy !== 1'b1 || timeout_err !== 1'b0 || dst_sel !== 3'b011) begin
            errors++;
            $display("FAIL wd_before_expiry: got busy=%b to=%b dst=%b want 1 0 011", busy, timeout_err, dst_sel);
        end
        tick;
        checks++;
        if (timeout_err !== 1'b1 || busy !== 1'b0 || src_sel !== 3'b000 || dst_sel !== 3'b000) begin
            errors++;
            $display("FAIL wd_expiry: got to=%b busy=%b src=%b dst=%b want 1 0 000 000", timeout_err, busy, src_sel, dst_sel);
        end
`ifdef CONV_SCHED_PERF_EN
        checks++;
        if (perf_phase !== 3'd2) begin
            errors++;
            $display("FAIL wd_perf_phase: got %0d want 2", perf_phase);
        end
`endif
        repeat (3) tick;
        checks++;
        if (timeout_err !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL wd_sticky: got to=%b busy=%b want 1 0", timeout_err, busy);
        end
    endtask

    task test_timeout_edge;
        ready = 1'b1;
        tick;
        ready = 1'b0;
        checks++;
        if (timeout_err !== 1'b0 || l0_start !== 1'b1) begin
            errors++;
            $display("FAIL wd_clear_on_start: got to=%b l0s=%b want 0 1", timeout_err, l0_start);
        end
        tick;
        repeat (99) tick;
        l0_done = 1'b1;
        tick;
        clear_dones;
        checks++;
        if (timeout_err !== 1'b0 || l0_start !== 1'b1 || dst_sel !== 3'b010 || busy !== 1'b1) begin
            errors++;
            $display("FAIL wd_done_on_edge: got to=%b l0s=%b dst=%b busy=%b want 0 1 010 1", timeout_err, l0_start, dst_sel, busy);
        end
        do_reset;
    endtask

    task test_async_reset;
        ready = 1'b1;
        tick;
        ready = 1'b0;
        tick;
        give_done(0);
        tick;
        give_done(0);
        tick;
        give_done(1);
        tick;
        checks++;
        if (busy !== 1'b1 || dst_sel !== 3'b100 || ksel !== 1'b1) begin
            errors++;
            $display("FAIL areset_precondition: got busy=%b dst=%b ksel=%b want 1 100 1", busy, dst_sel, ksel);
        end
        #3;
        reset = 1'b0;
        #1;
        checks++;
        if ({busy, l0_start, l1_start, l2_start, ksel, src_sel, dst_sel} !== 11'h000) begin
            errors++;
            $display("FAIL areset_immediate: got busy=%b st=%b%b%b ksel=%b src=%b dst=%b want all 0",
                     busy, l0_start, l1_start, l2_start, ksel, src_sel, dst_sel);
        end
        #2;
        reset = 1'b1;
        ready = 1'b1;
        tick;
        checks++;
        if (l0_start !== 1'b1 || dst_sel !== 3'b001 || ksel !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL areset_restart: got l0s=%b dst=%b ksel=%b busy=%b want 1 001 0 1", l0_start, dst_sel, ksel, busy);
        end
        ready = 1'b0;
    endtask

    initial begin
        test_reset;
        test_nominal;
        test_ready_held;
        test_stray_done;
        test_watchdog;
        test_timeout_edge;
        test_async_reset;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
